seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8, is the longest supported pattern length in bits (range 2..32).
REQ-002 Parameter CNT_W, default 8, is the match-counter width.
REQ-003 Parameters DEF_PATTERN (default 'b1001), DEF_LEN (default 4) and DEF_OVERLAP (default 1) set the configuration loaded at reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  1  serial data bit.
REQ-007 in_valid  input  1  qualifies in; when low, the bit is ignored and history holds.
REQ-008 cfg_load  input  1  one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
REQ-009 cfg_pattern  input  MAX_LEN  new pattern; bit cfg_len-1 is the first bit received, bit 0 is the last.
REQ-010 cfg_len  input  $clog2(MAX_LEN+1)  new pattern length.
REQ-011 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 count_clear  input  1  synchronous clear of match_count and count_sat.
REQ-013 out  output  1  one-cycle detection pulse.
REQ-014 match_count  output  CNT_W  saturating count of detections.
REQ-015 count_sat  output  1  sticky flag, high once match_count has reached all-ones.
REQ-016 cfg_err  output  1  one-cycle pulse when a cfg_load is rejected.

Function
REQ-017 On each rising edge with in_valid=1, the block shifts in into a MAX_LEN-bit history and increments the fill count, saturating at the active length.
REQ-018 A match occurs when fill count equals the active length and the low active-length history bits equal the active pattern; bits above the active length are masked.
REQ-019 out is registered and goes high for exactly the one cycle following the edge that sampled the completing bit, giving a latency of 1 clock.
REQ-020 In overlap mode, the history and fill count are kept after a match, so suffix/prefix overlaps are detected.
REQ-021 In non-overlap mode, the fill count is cleared to 0 on a match, so the next detection needs cfg_len new valid bits.
REQ-022 A cfg_load with cfg_len in 2..MAX_LEN updates the active configuration at that edge, clears the history and fill count, discards that cycle's in bit, and forces out=0 in the next cycle.
REQ-023 A cfg_load with cfg_len<2 or cfg_len>MAX_LEN leaves the configuration and history unchanged, and the sampled bit is processed normally.
REQ-024 cfg_err pulses high for one cycle after a rejected cfg_load (REQ-023).
REQ-025 match_count increments by 1 per match and holds at 2^CNT_W-1 once reached; count_sat is set in that cycle and stays set.
REQ-026 If count_clear and a match occur in the same cycle, count_clear wins: match_count=0 and count_sat=0; out still pulses.
REQ-027 With in_valid low, no state changes except cfg_load and count_clear actions; gaps between valid bits do not break a sequence.

Reset
REQ-028 While reset is high: out=0, match_count=0, count_sat=0, cfg_err=0, history=0, fill count=0, and the active configuration equals DEF_PATTERN/DEF_LEN/DEF_OVERLAP.
REQ-029 Reset asserted mid-sequence discards all partial history; detection restarts from the first valid bit after deassertion.

Structure
REQ-030 Package seq_det_pkg SHALL hold the default-configuration constants and the length-validity range constants.
REQ-031 The saturating counter SHALL be a sub-module, sat_counter (parameter CNT_W; inputs inc and clr; outputs count and sat).
REQ-032 All other logic (history, fill count, configuration registers, compare) stays in seq_detector_param.

Verification
REQ-033 Default config, valid bits 1,0,0,1,0,0,1 -> out pulses after bits 4 and 7; match_count=2.
REQ-034 cfg_load with pattern 'b1001, len 4, overlap 0, then bits 1,0,0,1,0,0,1 -> one pulse after bit 4; match_count=1.
REQ-035 cfg_load with pattern 'b110, len 3, then bits 1,1,[in_valid=0 for 3 cycles],0 -> one pulse; cfg_load with len 0 -> cfg_err pulse and 'b110 still active.
REQ-036 Default config, bits 1,0,0, assert reset for 1 cycle, then bit 1 -> no pulse; all outputs 0 during reset.
REQ-037 CNT_W=2, five matches -> match_count=3 and count_sat=1; count_clear coincident with a 6th match -> out pulses, match_count=0, count_sat=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial pattern detector:
// the configuration loaded at reset and the legal pattern-length range.
package seq_det_pkg;

    // Configuration that is active straight out of reset.
    localparam logic [31:0] DEF_PATTERN_C = 32'b1001;
    localparam int          DEF_LEN_C     = 4;
    localparam bit          DEF_OVERLAP_C = 1'b1;

    // Shortest pattern a cfg_load may select; shorter requests are rejected.
    localparam int LEN_MIN = 2;
    // Largest MAX_LEN the detector is designed for.
    localparam int LEN_MAX_LIMIT = 32;

endpackage

// File: rtl/seq_detector_param_if.sv
// Bus bundle between a stimulus source and the pattern detector.
//
// Qualifier semantics: `in` is only meaningful in a cycle where in_valid is
// high; there is no backpressure, so every valid bit is consumed at the
// rising edge it is presented. cfg_load and count_clear are single-cycle
// strobes, and out / cfg_err are single-cycle pulses.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clear;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;
    logic               cfg_err;

    // Stimulus side.
    modport master (
        output in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clear,
        input  out, match_count, count_sat, cfg_err
    );

    // Detector side.
    modport slave (
        input  in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clear,
        output out, match_count, count_sat, cfg_err
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag. A clear request
// takes priority over a coincident increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    // Next count: clear wins, otherwise increment until all-ones and hold.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_W'(1);
            end
            sat_d = sat_q | (count_d == CNT_MAX);
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector. Valid bits shift into a
// history register; a match fires when enough bits have arrived for the
// active length and the masked history equals the active pattern. Matches
// are reported as a registered one-cycle pulse and tallied by a saturating
// counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int          MAX_LEN     = 8,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] DEF_PATTERN = DEF_PATTERN_C,
    parameter int          DEF_LEN     = DEF_LEN_C,
    parameter bit          DEF_OVERLAP = DEF_OVERLAP_C
) (
    input logic                 clk,
    input logic                 reset,
    seq_detector_param_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // Ones in the low `len` positions; history bits above the active
    // length never take part in the compare.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < 32'(len));
        end
        return m;
    endfunction

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               out_q, out_d;
    logic               cfg_err_q, cfg_err_d;

    logic               cfg_ok;
    logic               match;
    logic [MAX_LEN-1:0] shift_hist;
    logic [LEN_W-1:0]   shift_fill;
    logic [CNT_W-1:0]   count;
    logic               sat;

    // A load is accepted only for lengths the history can actually hold.
    assign cfg_ok = bus.cfg_load
                  && (bus.cfg_len >= LEN_W'(LEN_MIN))
                  && (bus.cfg_len <= LEN_W'(MAX_LEN));

    // Next history/fill/config and match decision for this edge.
    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        pat_d      = pat_q;
        len_d      = len_q;
        ovl_d      = ovl_q;
        match      = 1'b0;
        cfg_err_d  = bus.cfg_load && !cfg_ok;
        shift_hist = {hist_q[MAX_LEN-2:0], bus.in};
        shift_fill = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;

        if (cfg_ok) begin
            // Accepted load restarts detection; this cycle's bit is dropped.
            pat_d  = bus.cfg_pattern;
            len_d  = bus.cfg_len;
            ovl_d  = bus.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            hist_d = shift_hist;
            fill_d = shift_fill;
            if ((shift_fill == len_q)
                && (((shift_hist ^ pat_q) & len_mask(len_q)) == '0)) begin
                match = 1'b1;
                // Non-overlap mode needs a full fresh pattern for the next hit.
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end
        out_d = match;
    end

    // State registers; reset restores the default configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= DEF_PATTERN[MAX_LEN-1:0];
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVERLAP;
            out_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            out_q     <= out_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (bus.count_clear),
        .count (count),
        .sat   (sat)
    );

    assign bus.out         = out_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.match_count = count;
    assign bus.count_sat   = sat;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. Two detectors see identical
// stimulus: one with the default 8-bit counter and one with a 2-bit counter
// so saturation is reachable in a few matches.
module tb_seq_detector_param;

    logic clk;
    logic reset;

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) a_if ();
    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) b_if ();

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    // Second detector mirrors the first one's inputs.
    assign b_if.in          = a_if.in;
    assign b_if.in_valid    = a_if.in_valid;
    assign b_if.cfg_load    = a_if.cfg_load;
    assign b_if.cfg_pattern = a_if.cfg_pattern;
    assign b_if.cfg_len     = a_if.cfg_len;
    assign b_if.cfg_overlap = a_if.cfg_overlap;
    assign b_if.count_clear = a_if.count_clear;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Each entry is {expected cfg_err, expected out} for the cycle after a step.
    logic [1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int exp_cnt_a;
    int exp_cnt_b;
    logic exp_sat_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".cnt_a"}, 32'(a_if.match_count), 32'(exp_cnt_a));
        chk({tag, ".sat_a"}, 32'(a_if.count_sat), 32'd0);
        chk({tag, ".cnt_b"}, 32'(b_if.match_count), 32'(exp_cnt_b));
        chk({tag, ".sat_b"}, 32'(b_if.count_sat), 32'(exp_sat_b));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_a"}, 32'(a_if.out), 32'd0);
        chk({tag, ".out_b"}, 32'(b_if.out), 32'd0);
        chk({tag, ".err_a"}, 32'(a_if.cfg_err), 32'd0);
        chk({tag, ".cnt_a"}, 32'(a_if.match_count), 32'd0);
        chk({tag, ".cnt_b"}, 32'(b_if.match_count), 32'd0);
        chk({tag, ".sat_b"}, 32'(b_if.count_sat), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Present one cycle of input, then compare the registered response.
    // cfg_load / count_clear are set by the caller beforehand if wanted.
    task automatic step(input string tag, input logic b, input logic v,
                        input logic exp_out, input logic exp_err);
        logic       clr;
        logic [1:0] e;
        a_if.in       = b;
        a_if.in_valid = v;
        clr           = a_if.count_clear;
        exp_q.push_back({exp_err, exp_out});
        @(posedge clk);
        #1;
        a_if.cfg_load    = 1'b0;
        a_if.count_clear = 1'b0;
        a_if.in_valid    = 1'b0;
        if (clr) begin
            exp_cnt_a = 0;
            exp_cnt_b = 0;
            exp_sat_b = 1'b0;
        end else if (exp_out) begin
            if (exp_cnt_a < 255) exp_cnt_a++;
            if (exp_cnt_b < 3) exp_cnt_b++;
            if (exp_cnt_b == 3) exp_sat_b = 1'b1;
        end
        e = exp_q.pop_front();
        chk({tag, ".out_a"}, 32'(a_if.out), 32'(e[0]));
        chk({tag, ".out_b"}, 32'(b_if.out), 32'(e[0]));
        chk({tag, ".err_a"}, 32'(a_if.cfg_err), 32'(e[1]));
        chk_counts(tag);
    endtask

    task automatic bits(input string tag, input logic [15:0] seq, input logic [15:0] exp,
                        input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, seq[i], 1'b1, exp[i], 1'b0);
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        a_if.cfg_pattern = pat;
        a_if.cfg_len     = len;
        a_if.cfg_overlap = ovl;
        a_if.cfg_load    = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk_all_zero({tag, ".async"});
        @(posedge clk);
        #1;
        chk_all_zero({tag, ".held"});
        reset     = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        exp_sat_b = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset            = 1'b1;
        a_if.in          = 1'b0;
        a_if.in_valid    = 1'b0;
        a_if.cfg_load    = 1'b0;
        a_if.cfg_pattern = '0;
        a_if.cfg_len     = '0;
        a_if.cfg_overlap = 1'b0;
        a_if.count_clear = 1'b0;
        exp_cnt_a        = 0;
        exp_cnt_b        = 0;
        exp_sat_b        = 1'b0;

        #1;
        chk_all_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("por_held");
        reset = 1'b0;

        // Default 1001 overlapping: pulses after bits 4 and 7.
        bits("dflt", 16'b1001001, 16'b0001001, 7);
        chk("dflt.total", 32'(a_if.match_count), 32'd2);

        a_if.count_clear = 1'b1;
        step("clr1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Non-overlapping 1001: only the first occurrence counts.
        load(8'b1001, 4'd4, 1'b0);
        step("ld_novl", 1'b1, 1'b1, 1'b0, 1'b0);
        bits("novl", 16'b1001001, 16'b0001000, 7);
        chk("novl.total", 32'(a_if.match_count), 32'd1);

        a_if.count_clear = 1'b1;
        step("clr2", 1'b0, 1'b0, 1'b0, 1'b0);

        // 110 with an invalid gap before the last bit; gap bits are ignored.
        load(8'b110, 4'd3, 1'b1);
        step("ld_110", 1'b1, 1'b1, 1'b0, 1'b0);
        bits("gap_a", 16'b11, 16'b00, 2);
        for (int i = 0; i < 3; i++) begin
            step("gap_idle", 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        step("gap_last", 1'b0, 1'b1, 1'b1, 1'b0);

        // Rejected load (len 0): error pulse, bit still shifted, 110 kept.
        load(8'hFF, 4'd0, 1'b0);
        step("rej0", 1'b1, 1'b1, 1'b0, 1'b1);
        bits("rej0_after", 16'b10, 16'b01, 2);

        // Rejected load (len above MAX_LEN).
        load(8'h00, 4'd9, 1'b0);
        step("rej9", 1'b1, 1'b1, 1'b0, 1'b1);
        bits("rej9_after", 16'b10, 16'b01, 2);

        // Accepted load drops its own bit: only two bits of 110 remain.
        load(8'b110, 4'd3, 1'b1);
        step("ld_drop", 1'b1, 1'b1, 1'b0, 1'b0);
        bits("drop", 16'b10, 16'b00, 2);

        // Reset mid-sequence restores defaults and discards history.
        do_reset("rst1");
        bits("pre_rst", 16'b100, 16'b000, 3);
        do_reset("rst2");
        bits("post_rst", 16'b1001, 16'b0001, 4);

        a_if.count_clear = 1'b1;
        step("clr3", 1'b0, 1'b0, 1'b0, 1'b0);

        // Five overlapping matches saturate the 2-bit counter.
        bits("sat_first", 16'b1001, 16'b0001, 4);
        for (int k = 0; k < 4; k++) begin
            bits("sat_more", 16'b001, 16'b001, 3);
        end
        chk("sat.cnt_b", 32'(b_if.match_count), 32'd3);
        chk("sat.flag_b", 32'(b_if.count_sat), 32'd1);
        chk("sat.cnt_a", 32'(a_if.match_count), 32'd5);

        // Clear coincident with a sixth match: pulse still appears, counts clear.
        bits("clr_match", 16'b00, 16'b00, 2);
        a_if.count_clear = 1'b1;
        step("clr_match_hit", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_match.cnt_b", 32'(b_if.match_count), 32'd0);
        chk("clr_match.flag_b", 32'(b_if.count_sat), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
